// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register plus a small {instr, pc} FIFO that sits
// between InstructionMemory and decode; redirects flush and refetch.
module instruction_fetch #(
  parameter int unsigned DEPTH        = 2,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_read_data,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus8
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [31:0]   pc;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          push;

  assign pop  = out_valid & out_ready;
  assign push = ~branch_valid & ((count != FULL) | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= RESET_VECTOR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (branch_valid) begin
      // flush: a pop this cycle still counts as taken by decode
      pc     <= {branch_target[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push & ~pop) begin
        count <= count + CNT_ONE;
      end else if (pop & ~push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // storage is not reset; entries are only read once written
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= imem_read_data;
      pc_q[wr_ptr]    <= pc;
    end
  end

  assign imem_address = pc;
  assign out_valid    = (count != '0);
  assign out_instr    = instr_q[rd_ptr];
  assign out_pc       = pc_q[rd_ptr];
  assign out_pc_plus8 = pc_q[rd_ptr] + 32'd8;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: random + directed stimulus against a queue model
// of the fetch stage; a second instance covers PC wrap-around.
module tb_instruction_fetch;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] RVW = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_address;
  logic [31:0] imem_read_data;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus8;

  logic        reset_n_w;
  logic [31:0] addr_w;
  logic [31:0] rdata_w;
  logic        valid_w;
  logic [31:0] instr_w;
  logic [31:0] pc_w;
  logic [31:0] plus8_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hE3A0_0000 | {16'h0, a[17:2]};
  endfunction

  assign imem_read_data = word(imem_address);
  assign rdata_w        = word(addr_w);

  instruction_fetch #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_address(imem_address), .imem_read_data(imem_read_data),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus8(out_pc_plus8)
  );

  instruction_fetch #(.DEPTH(DEPTH), .RESET_VECTOR(RVW)) dut_w (
    .clk(clk), .reset_n(reset_n_w),
    .imem_address(addr_w), .imem_read_data(rdata_w),
    .branch_valid(1'b0), .branch_target(32'h0),
    .out_valid(valid_w), .out_ready(1'b1),
    .out_instr(instr_w), .out_pc(pc_w), .out_pc_plus8(plus8_w)
  );

  // model: queue of fetched pcs plus the fetch address
  logic [31:0] mq[$];
  logic [31:0] mpc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input logic [31:0] v);
    mq.delete();
    mpc = v;
  endtask

  task automatic model_step();
    bit pop;
    pop = (mq.size() != 0) && out_ready;
    if (branch_valid) begin
      mq.delete();
      mpc = {branch_target[31:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        mq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic check_all();
    check("valid", 32'(out_valid), 32'(mq.size() != 0));
    check("addr", imem_address, mpc);
    if (mq.size() != 0) begin
      check("pc", out_pc, mq[0]);
      check("instr", out_instr, word(mq[0]));
      check("plus8", out_pc_plus8, mq[0] + 32'd8);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset_n       = 1'b0;
    reset_n_w     = 1'b0;
    out_ready     = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 32'h0;
    model_reset(RV);
    repeat (2) begin
      @(negedge clk);
      check_all();
    end
    reset_n = 1'b1;

    // stall right after reset, then stream
    repeat (6) step();
    check("stall_addr", imem_address, 32'h8);
    check("stall_head", out_pc, 32'h0);
    out_ready = 1'b1;
    repeat (40) step();

    // redirect while full
    out_ready = 1'b0;
    repeat (2) step();
    branch_valid  = 1'b1;
    branch_target = 32'h0000_0103;
    step();
    check("br_valid", 32'(out_valid), 32'h0);
    check("br_addr", imem_address, 32'h100);
    branch_valid = 1'b0;
    step();
    check("br_pc", out_pc, 32'h100);
    check("br_instr", out_instr, 32'hE3A0_0040);

    // redirect together with a pop
    step();
    check("bp_head", out_pc, 32'h100);
    out_ready     = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 32'h0000_0200;
    step();
    check("bp_valid", 32'(out_valid), 32'h0);
    branch_valid = 1'b0;
    step();
    check("bp_pc", out_pc, 32'h200);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      out_ready     = ($urandom_range(0, 3) != 0);
      branch_valid  = ($urandom_range(0, 7) == 0);
      branch_target = $urandom & 32'h000F_FFFF;
      step();
    end

    // mid-run reset with two entries buffered
    out_ready     = 1'b0;
    branch_valid  = 1'b1;
    branch_target = 32'h40;
    step();
    branch_valid = 1'b0;
    repeat (2) step();
    check("mr_pc", out_pc, 32'h40);
    reset_n = 1'b0;
    #1;
    model_reset(RV);
    check("mr_valid", 32'(out_valid), 32'h0);
    check("mr_addr", imem_address, RV);
    #2;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step();
    check("mr_restart", out_pc, RV);
    repeat (4) step();

    // wrap-around instance
    reset_n = 1'b0;
    @(negedge clk);
    check("w_rst_addr", addr_w, RVW);
    check("w_rst_valid", 32'(valid_w), 32'h0);
    reset_n_w = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] e;
      e = RVW + 32'(4 * k);
      @(posedge clk);
      @(negedge clk);
      check("w_valid", 32'(valid_w), 32'h1);
      check("w_pc", pc_w, e);
      check("w_instr", instr_w, word(e));
      check("w_plus8", plus8_w, e + 32'd8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage that sits directly upstream of `InstructionMemory`. It holds the program counter and drives the byte address into the memory. It captures the combinationally returned 32-bit instruction word into a small FIFO and presents `{instruction, pc}` to decode over a valid/ready handshake. It also absorbs decode stalls without losing fetched words, and flushes on branch redirects.

## Interface

Parameters:
- `DEPTH`, 2: number of FIFO entries; power of two, 2..8.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `imem_address`, output, 32: byte address to `InstructionMemory`; equals the PC register.
- `imem_read_data`, input, 32: instruction word; combinational function of `imem_address` in the same cycle.
- `branch_valid`, input, 1: redirect request from execute.
- `branch_target`, input, 32: redirect byte address; bits [1:0] are ignored and forced to 0.
- `out_valid`, output, 1: FIFO head holds a valid instruction.
- `out_ready`, input, 1: decode accepts the head this cycle.
- `out_instr`, output, 32: instruction at the FIFO head.
- `out_pc`, output, 32: byte address of `out_instr`.
- `out_pc_plus8`, output, 32: `out_pc + 8` modulo 2^32, the ARM-visible PC for the instruction.

## Operation

- State:
  - `pc` (32 bits).
  - `DEPTH`-entry storage of `{instr, pc}`.
  - `wr_ptr` and `rd_ptr` (log2 `DEPTH` bits, wrap modulo `DEPTH`).
  - `count` (0..`DEPTH`).
- Control signals:
  - `pop = out_valid & out_ready`.
  - `push = !branch_valid & (count < DEPTH | pop)`.
- Push: write `{imem_read_data, pc}` at `wr_ptr`, then `wr_ptr++` and `pc <= pc + 4`, wrapping from 32'hFFFF_FFFC to 0.
- Pop: `rd_ptr++`.
- Count update: `count` changes by +1 on push only, −1 on pop only, and is unchanged when both occur.
- Full FIFO with pop: a push is allowed in the same cycle, so throughput is one instruction per cycle at full occupancy.
- Full FIFO without pop: `pc` holds and the memory address stays stable. No fetch is lost, because the word is re-read when space frees.
- Branch redirect (`branch_valid=1`):
  - `pc <= {branch_target[31:2], 2'b00}`.
  - `count`, `wr_ptr`, and `rd_ptr` are all cleared to 0.
  - No push occurs that cycle.
  - A pop handshake occurring in that cycle is still counted as accepted by decode. The flush discards every remaining entry.
- Back-to-back branches: each cycle's target wins, and no push occurs until the first cycle with `branch_valid=0`.
- Outputs:
  - `out_valid = (count != 0)`.
  - `out_instr`, `out_pc`, and `out_pc_plus8` come from entry `rd_ptr`.
  - The output data must be don't-care when `out_valid=0`. The bench must not check it.
  - Head data must not change while `out_valid=1 & out_ready=0` and no branch is asserted.

## Timing

- Reset, applied asynchronously while `reset_n=0`:
  - `pc = RESET_VECTOR`, so `imem_address = RESET_VECTOR` during reset.
  - `count = 0`, `wr_ptr = rd_ptr = 0`.
  - `out_valid = 0`.
  - Storage contents are not reset.
- Deassertion of `reset_n` is synchronized by the surrounding design. The first push occurs on the first rising edge with `reset_n=1`.
- Fetch latency: a word at address A is visible on `out_*` one cycle after the edge where `pc=A` was pushed.
- Branch latency: the target word is pushed on the edge after the redirect edge. `out_valid` is 0 for exactly one cycle after a redirect, then the target instruction appears.
- Reset asserted mid-operation: all state returns immediately to reset values, and in-flight entries are discarded.

## Test plan

- Memory preload and streaming: load word i = 32'hE3A0_0000 | i, hold `out_ready=1`, release reset.
  - Cycle k after the first edge shows `out_valid=1`, `out_pc=4(k-1)`, `out_instr=E3A0_0000|(k-1)`, and `out_pc_plus8=out_pc+8`.
  - Stop when the memory image ends; the run must report 0 errors.
- Stall, DEPTH=2: hold `out_ready=0` for 5 cycles after the first valid.
  - FIFO holds pc 0 and 4, `imem_address` stays at 8, and the head stays at pc 0.
  - On release, pcs 0, 4, 8, 12 appear consecutively with no gaps or duplicates.
- Branch redirect: assert `branch_valid` with `branch_target=32'h0000_0103` while the FIFO is full.
  - The next cycle shows `out_valid=0` and `imem_address=32'h100`.
  - The following cycle shows `out_pc=32'h100` and `out_instr` equal to word 64.
- Branch plus pop in the same cycle: the head is consumed exactly once, the other entry is dropped, and the next output is the target.
- Wrap-around: set `RESET_VECTOR=32'hFFFF_FFF8` with `out_ready=1`.
  - `out_pc` sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - `out_pc_plus8` at FFFF_FFFC equals 0000_0004.
- Mid-run reset: pulse `reset_n=0` for a half cycle with 2 entries buffered.
  - `out_valid` drops to 0 immediately and `imem_address` becomes `RESET_VECTOR`.
  - After release, the stream restarts at `RESET_VECTOR`.
